mem_arbiter: RTL and testbench

//   Shares the single 256-bit off-chip Data Memory port between two cache

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one 256-bit Data Memory port between the icache (port 0)
// and the dcache (port 1). It arbitrates whole transactions and flags a memory that never acks.
module mem_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_enable_i,
  input  logic         req0_write_i,
  input  logic [31:0]  req0_addr_i,
  input  logic [255:0] req0_data_i,
  output logic         req0_ack_o,
  input  logic         req1_enable_i,
  input  logic         req1_write_i,
  input  logic [31:0]  req1_addr_i,
  input  logic [255:0] req1_data_i,
  output logic         req1_ack_o,
  output logic [255:0] rd_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic         timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             gnt_en;
  logic             pick1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == TMO) ? v : v + 1'b1;
  endfunction

  assign rd_data_o = mem_data_i;
  assign cnt_nxt   = sat_inc(cnt);
  assign gnt_en    = (state == GNT1) ? req1_enable_i : req0_enable_i;
  // Round-robin favours the port that did not complete last; fixed priority favours the dcache.
  assign pick1     = RR_EN ? ~last_grant : 1'b1;

  // Memory side is a combinational pass-through of the granted port.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    req0_ack_o   = 1'b0;
    req1_ack_o   = 1'b0;
    unique case (state)
      GNT0: begin
        mem_enable_o = req0_enable_i;
        mem_write_o  = req0_write_i;
        mem_addr_o   = req0_addr_i;
        mem_data_o   = req0_data_i;
        req0_ack_o   = mem_ack_i;
      end
      GNT1: begin
        mem_enable_o = req1_enable_i;
        mem_write_o  = req1_write_i;
        mem_addr_o   = req1_addr_i;
        mem_data_o   = req1_data_i;
        req1_ack_o   = mem_ack_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      timeout_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (req0_enable_i && req1_enable_i) state <= pick1 ? GNT1 : GNT0;
          else if (req1_enable_i)             state <= GNT1;
          else if (req0_enable_i)             state <= GNT0;
        end
        GNT0, GNT1: begin
          cnt <= cnt_nxt;
          // cnt_nxt counts grant cycles already spent without an ack.
          if (TIMEOUT != 0 && cnt_nxt == TMO && !mem_ack_i) timeout_o <= 1'b1;
          if (mem_ack_i) begin
            state      <= IDLE;
            last_grant <= (state == GNT1);
          end else if (!gnt_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset, a cycle table, hand sequences for timeout/reset/priority,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic         en[2];
  logic         wr[2];
  logic [31:0]  addr[2];
  logic [255:0] wdata[2];
  logic         mem_ack;
  logic [255:0] mem_data;

  logic         ack0, ack1, men, mwr, tmo;
  logic [31:0]  maddr;
  logic [255:0] mdata, rdata;

  logic         f_en0, f_en1, f_ack;
  logic         f_ack0, f_ack1, f_men, f_mwr, f_tmo;
  logic [31:0]  f_maddr;
  logic [255:0] f_mdata, f_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RR_EN(1'b1), .TIMEOUT(T), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(en[0]), .req0_write_i(wr[0]), .req0_addr_i(addr[0]), .req0_data_i(wdata[0]),
    .req0_ack_o(ack0),
    .req1_enable_i(en[1]), .req1_write_i(wr[1]), .req1_addr_i(addr[1]), .req1_data_i(wdata[1]),
    .req1_ack_o(ack1),
    .rd_data_o(rdata), .mem_data_i(mem_data), .mem_ack_i(mem_ack),
    .mem_data_o(mdata), .mem_addr_o(maddr), .mem_enable_o(men), .mem_write_o(mwr),
    .timeout_o(tmo)
  );

  mem_arbiter #(.RR_EN(1'b0), .TIMEOUT(0), .CNT_W(4)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(f_en0), .req0_write_i(wr[0]), .req0_addr_i(addr[0]), .req0_data_i(wdata[0]),
    .req0_ack_o(f_ack0),
    .req1_enable_i(f_en1), .req1_write_i(wr[1]), .req1_addr_i(addr[1]), .req1_data_i(wdata[1]),
    .req1_ack_o(f_ack1),
    .rd_data_o(f_rdata), .mem_data_i(mem_data), .mem_ack_i(f_ack),
    .mem_data_o(f_mdata), .mem_addr_o(f_maddr), .mem_enable_o(f_men), .mem_write_o(f_mwr),
    .timeout_o(f_tmo)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 256'(act), 256'(exp));
  endtask

  task automatic chki(input string name, input int act, input int exp);
    chk(name, 256'(unsigned'(act)), 256'(unsigned'(exp)));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Reference model: who owns the memory, who completed last, grant age, sticky timeout.
  int   m_owner, m_last, m_age;
  logic m_tmo;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_age = 0; m_tmo = 1'b0;
  endtask

  task automatic model_expect(output logic [4:0] ctrl, output logic [31:0] a, output logic [255:0] d);
    if (m_owner < 0) begin
      ctrl = {4'b0000, m_tmo}; a = '0; d = '0;
    end else begin
      ctrl = {(m_owner == 0) && mem_ack, (m_owner == 1) && mem_ack, en[m_owner], wr[m_owner], m_tmo};
      a = addr[m_owner];
      d = wdata[m_owner];
    end
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      if (en[0] || en[1]) begin
        if (en[0] && en[1]) m_owner = (T > 0 && 1'b1) ? 1 - m_last : 1;
        else m_owner = en[1] ? 1 : 0;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age >= T && !mem_ack) m_tmo = 1'b1;
      if (mem_ack) begin
        m_last = m_owner; m_owner = -1;
      end else if (!en[m_owner]) begin
        m_owner = -1;
      end
    end
  endtask

  typedef struct {
    logic       en0, en1, ack;
    logic [1:0] own;
    logic       ack0, ack1, men;
  } vec_t;

  initial begin
    vec_t tbl[19];
    logic [4:0]   e_ctrl;
    logic [31:0]  e_addr;
    logic [255:0] e_data;
    logic         got_ack[2];
    int           txn, gcyc, a0;
    logic [255:0] rd_val;

    en[0] = 1'b1; en[1] = 1'b1; wr[0] = 1'b1; wr[1] = 1'b0;
    addr[0] = 32'h0000_0080; addr[1] = 32'h0000_0400;
    wdata[0] = {32{8'hA5}}; wdata[1] = {32{8'h5A}};
    mem_ack = 1'b1; mem_data = rand256();
    f_en0 = 1'b0; f_en1 = 1'b0; f_ack = 1'b0;

    #12;
    chk("rst_ctrl", 256'({ack0, ack1, men, mwr, tmo}), 256'(0));
    chk("rst_addr", 256'(maddr), 256'(0));
    chk("rst_data", mdata, 256'(0));
    chk("rst_fp_ctrl", 256'({f_ack0, f_ack1, f_men, f_tmo}), 256'(0));

    //            en0   en1   ack   own   ack0  ack1  men
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      en[0] = tbl[i].en0; en[1] = tbl[i].en1; mem_ack = tbl[i].ack; mem_data = rand256();
      @(negedge clk);
      e_addr = (tbl[i].own == 2'd0) ? addr[0] : (tbl[i].own == 2'd1) ? addr[1] : 32'h0;
      e_data = (tbl[i].own == 2'd0) ? wdata[0] : (tbl[i].own == 2'd1) ? wdata[1] : '0;
      chk($sformatf("tbl%0d_ctrl", i), 256'({ack0, ack1, men, mwr, tmo}),
          256'({tbl[i].ack0, tbl[i].ack1, tbl[i].men,
                (tbl[i].own == 2'd0) ? wr[0] : (tbl[i].own == 2'd1) ? wr[1] : 1'b0, 1'b0}));
      chk($sformatf("tbl%0d_addr", i), 256'(maddr), 256'(e_addr));
      chk($sformatf("tbl%0d_wdata", i), mdata, e_data);
      if (tbl[i].ack0 || tbl[i].ack1) chk($sformatf("tbl%0d_rdata", i), rdata, mem_data);
      @(posedge clk); #1;
    end
    en[0] = 1'b0; en[1] = 1'b0; mem_ack = 1'b0;

    // Port 1 read, memory acks 10 cycles after enable; the long grant also trips timeout.
    do_reset();
    en[1] = 1'b1;
    @(negedge clk); chk1("rd_idle_men", men, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk1("rd_grant_men", men, 1'b1); chk("rd_grant_addr", 256'(maddr), 256'(32'h400));
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin mem_ack = 1'b1; rd_val = rand256(); mem_data = rd_val; end
      @(negedge clk);
      if (k < 10) chk1($sformatf("rd_wait%0d_ack1", k), ack1, 1'b0);
    end
    chk1("rd_ack1", ack1, 1'b1);
    chk1("rd_ack0", ack0, 1'b0);
    chk("rd_data", rdata, rd_val);
    chk1("rd_timeout", tmo, 1'b1);
    @(posedge clk); #1 mem_ack = 1'b0; en[1] = 1'b0;
    @(negedge clk); chk1("rd_after_men", men, 1'b0); chk1("rd_after_ack1", ack1, 1'b0);

    // Port 0 write that the memory never acks: timeout after exactly T grant cycles.
    do_reset();
    en[0] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk1($sformatf("tmo_cyc%0d", k), tmo, k >= T);
      if (k == 0) begin
        chk1("wr_mem_write", mwr, 1'b1);
        chk("wr_mem_data", mdata, {32{8'hA5}});
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    chk1("tmo_cleared", tmo, 1'b0);
    chk1("tmo_rst_men", men, 1'b0);
    #1 rst = 1'b0; en[0] = 1'b0;

    // Asynchronous reset in the middle of a grant cycle.
    do_reset();
    en[0] = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b1;
    #2 chk1("arst_pre_ack0", ack0, 1'b1);
    rst = 1'b1; #1;
    chk1("arst_men", men, 1'b0);
    chk1("arst_ack0", ack0, 1'b0);
    chk1("arst_ack1", ack1, 1'b0);
    #1 rst = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk1("arst_regrant_men", men, 1'b1); chk("arst_regrant_addr", 256'(maddr), 256'(addr[0]));
    @(posedge clk); #1 en[0] = 1'b0;

    // Fixed priority, both held: dcache wins every transaction; TIMEOUT=0 never flags.
    do_reset();
    f_en0 = 1'b1; f_en1 = 1'b1; txn = 0; gcyc = 0; a0 = 0;
    for (int c = 0; c < 200 && txn < 3; c++) begin
      @(posedge clk); #1;
      if (f_men) begin gcyc++; f_ack = (gcyc == ((txn == 0) ? 20 : 3)); end
      else begin gcyc = 0; f_ack = 1'b0; end
      @(negedge clk);
      if (f_ack0) a0++;
      if (f_ack) begin
        chk1($sformatf("fp_txn%0d_ack1", txn), f_ack1, 1'b1);
        chk($sformatf("fp_txn%0d_addr", txn), 256'(f_maddr), 256'(addr[1]));
        txn++;
      end
    end
    @(posedge clk); #1 f_en0 = 1'b0; f_en1 = 1'b0; f_ack = 1'b0;
    chki("fp_txns", txn, 3);
    chki("fp_port0_acks", a0, 0);
    chk1("fp_timeout", f_tmo, 1'b0);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    got_ack[0] = 1'b0; got_ack[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (en[n] && got_ack[n]) begin
          en[n] = ($urandom % 3 == 0);
          if (en[n]) begin wr[n] = $urandom; addr[n] = $urandom; wdata[n] = rand256(); end
        end else if (en[n]) begin
          if ($urandom % 20 == 0) en[n] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          en[n] = 1'b1; wr[n] = $urandom; addr[n] = $urandom; wdata[n] = rand256();
        end
      end
      mem_ack  = (m_owner >= 0) ? ($urandom % 4 == 0) : ($urandom % 16 == 0);
      mem_data = rand256();
      @(negedge clk);
      model_expect(e_ctrl, e_addr, e_data);
      chk($sformatf("rnd%0d_ctrl", cyc), 256'({ack0, ack1, men, mwr, tmo}), 256'(e_ctrl));
      chk($sformatf("rnd%0d_addr", cyc), 256'(maddr), 256'(e_addr));
      chk($sformatf("rnd%0d_wdata", cyc), mdata, e_data);
      if (e_ctrl[4] || e_ctrl[3]) chk($sformatf("rnd%0d_rdata", cyc), rdata, mem_data);
      got_ack[0] = e_ctrl[4];
      got_ack[1] = e_ctrl[3];
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
